gpio_do_arb: RTL

GPIO_DO_ARB -- requirements
Module: gpio_do_arb

---
 rtl/gpio_do_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gpio_do_arb.sv
// Round-robin arbiter: four requesters share one GPIO output-data register.
// Optional grant locking is compiled in with `define GPIO_ARB_LOCK_EN.
module gpio_do_arb #(
  parameter int DATA_W = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [3:0]            REQ,
  input  logic [7:0]            OP,
  input  logic [4*DATA_W-1:0]   MASK,
`ifdef GPIO_ARB_LOCK_EN
  input  logic [3:0]            LOCK,
`endif
  output logic [3:0]            ACK,
  output logic                  GNT_VLD,
  output logic [1:0]            GNT_ID,
  output logic [DATA_W-1:0]     GPIO_DO
);

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_TOG = 2'b10;

  function automatic logic [DATA_W-1:0] apply_op(input logic [1:0]        op,
                                                 input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] m);
    case (op)
      OP_SET:  apply_op = cur | m;
      OP_CLR:  apply_op = cur & ~m;
      OP_TOG:  apply_op = cur ^ m;
      default: apply_op = m;
    endcase
  endfunction

  logic [1:0]        ptr;
  logic [3:0]        elig_p0;
  logic              vld_p0;
  logic [1:0]        sel_p0;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] mask_p0;
  logic [1:0]        idx;

`ifdef GPIO_ARB_LOCK_EN
  logic       lock_act;
  logic [1:0] lock_id;
  logic [2:0] lock_cnt;
  logic       lock_hold;

  assign lock_hold = lock_act & REQ[lock_id] & LOCK[lock_id];
`endif

  // Stage 0: eligibility and round-robin pick of one requester
  always_comb begin
    elig_p0 = REQ & ~ACK;
`ifdef GPIO_ARB_LOCK_EN
    if (lock_hold) elig_p0 = elig_p0 & (4'b0001 << lock_id);
`endif
    vld_p0  = 1'b0;
    sel_p0  = ptr;
    op_p0   = OP[1:0];
    mask_p0 = MASK[DATA_W-1:0];
    idx     = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!vld_p0 && elig_p0[idx]) begin
        vld_p0  = 1'b1;
        sel_p0  = idx;
        op_p0   = OP[2*idx +: 2];
        mask_p0 = MASK[DATA_W*idx +: DATA_W];
      end
    end
  end

  // Stage 1: apply the update, register the grant, advance the pointer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr     <= 2'd0;
      ACK     <= 4'd0;
      GNT_VLD <= 1'b0;
      GNT_ID  <= 2'd0;
      GPIO_DO <= '0;
    end else begin
      GNT_VLD <= vld_p0;
      ACK     <= vld_p0 ? (4'b0001 << sel_p0) : 4'd0;
      if (vld_p0) begin
        GNT_ID  <= sel_p0;
        ptr     <= sel_p0 + 2'd1;
        GPIO_DO <= apply_op(op_p0, GPIO_DO, mask_p0);
      end
    end
  end

`ifdef GPIO_ARB_LOCK_EN
  // lock_cnt counts grants inside the current lock; the 8th grant releases it
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_act <= 1'b0;
      lock_id  <= 2'd0;
      lock_cnt <= 3'd0;
    end else if (vld_p0) begin
      if (lock_hold) begin
        if (lock_cnt == 3'd7) begin
          lock_act <= 1'b0;
          lock_cnt <= 3'd0;
        end else begin
          lock_cnt <= lock_cnt + 3'd1;
        end
      end else if (LOCK[sel_p0]) begin
        lock_act <= 1'b1;
        lock_id  <= sel_p0;
        lock_cnt <= 3'd1;
      end else begin
        lock_act <= 1'b0;
        lock_cnt <= 3'd0;
      end
    end else if (!lock_hold) begin
      lock_act <= 1'b0;
      lock_cnt <= 3'd0;
    end
  end
`endif

endmodule
